dcache_refill_controller: RTL and testbench
===========================================

Name: dcache_refill_controller

Overview:
Sequences the single main-memory port behind the L1 data cache. Accepts one repair (miss refill) request at a time from the MSHR, drains a single-entry victim writeback buffer fed by the data cache, issues block reads/writes to memory, and installs returned blocks into the data cache. For store misses it merges the store word into the fill block and installs the block dirty. Sits between miss_status_history_register, data_cache and the memory interface.

Parameters:
BLOCK_BITS, 128, cache block width in bits (multiple of 32)
TIMEOUT_CYCLES, 1024, memory response watchdog limit
ROB_ENTRIES, 32, ROB depth (sets rob index width RW = clog2(ROB_ENTRIES))

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
flush_i  in  1  pipeline flush
repair_req_i  in  1  MSHR has a repair pending
repair_req_addr_i  in  32  miss address
repair_req_data_i  in  32  store data (store misses)
repair_is_store_i  in  1  repair is for a store
repair_req_rob_idx_i  in  RW  ROB index of request
repair_ack_o  out  1  request accepted (1-cycle pulse)
repair_complete_o  out  1  block installed (1-cycle pulse)
repair_rob_idx_o  out  RW  ROB index of completed repair
wb_vld_i  in  1  data cache evicts a dirty block
wb_addr_i  in  32  victim block address
wb_data_i  in  BLOCK_BITS  victim data
wb_rdy_o  out  1  writeback buffer empty
mem_req_vld_o  out  1  memory request valid
mem_req_we_o  out  1  1=block write, 0=block read
mem_req_addr_o  out  32  block-aligned address
mem_req_data_o  out  BLOCK_BITS  write data
mem_req_rdy_i  in  1  memory accepts request
mem_resp_vld_i  in  1  read data valid
mem_resp_data_i  in  BLOCK_BITS  read block
cache_wr_en_o  out  1  install block
cache_is_repair_o  out  1  write is a repair fill
cache_is_repair_dirty_o  out  1  installed block dirty
cache_wr_addr_o  out  32  install address
cache_wr_data_o  out  BLOCK_BITS  install data
timeout_err_o  out  1  sticky watchdog error

Behaviour:
- Reset (rst_i low, async): state IDLE, buffers empty, all outputs 0, counters 0.
- WB buffer: captures wb_* when wb_vld_i && wb_rdy_o; wb_rdy_o = !wb_buf_vld. Capture is legal in any state.
- States: IDLE, WB_REQ, FILL_REQ, FILL_WAIT, FILL_WRITE.
- IDLE: if wb_buf_vld -> WB_REQ (writeback has priority). Else if repair_req_i -> latch addr/data/is_store/rob_idx, pulse repair_ack_o same cycle, -> FILL_REQ.
- A fill starts only with the WB buffer empty, so an eviction caused by the install always finds room.
- WB_REQ: mem_req_vld_o=1, we=1, addr/data from buffer; on mem_req_rdy_i clear buffer -> IDLE. No response expected for writes.
- FILL_REQ: vld=1, we=0, addr = latched addr with low clog2(BLOCK_BITS/8) bits zeroed; on rdy -> FILL_WAIT, clear watchdog.
- FILL_WAIT: on mem_resp_vld_i latch data -> FILL_WRITE. Watchdog increments per cycle; reaching TIMEOUT_CYCLES sets timeout_err_o (sticky until reset) and stays in FILL_WAIT.
- FILL_WRITE (1 cycle): cache_wr_en_o=1, is_repair=1, dirty=is_store; data = fill block with, if store, word index addr[clog2(BLOCK_BITS/8)-1:2] replaced by store data. repair_complete_o pulses with rob idx. -> IDLE.
- Request-to-install latency: 1 (ack) + mem handshake + response latency + 1.
- mem_req_vld_o held with stable addr/data until mem_req_rdy_i (no retraction).
- flush_i: accepted fill runs to completion and installs (data is architecturally valid), but repair_complete_o is suppressed if flush seen between ack and FILL_WRITE (inclusive). Pending WB unaffected. flush_i in IDLE blocks new acceptance that cycle.
- repair_ack_o and repair_complete_o never high in the same cycle.

Decomposition:
- Shared cache package: BLOCK_BITS, offset/word-index widths, refill state enum, block typedef; reuse cache_data_block where widths match.
- One sub-module natural: dcache_wb_buffer (single-entry victim buffer with vld/rdy).

Test Plan:
- Load miss addr 0x0000_1234, mem rdy immediate, resp after 3 cycles data D -> one read at 0x0000_1230, install D clean at 0x1230, complete pulse with rob idx 5.
- Store miss addr 0x0000_1238 data 0xDEADBEEF, resp all-zero -> installed block word2 = 0xDEADBEEF, others 0, dirty=1.
- WB pending (addr 0x4000) and repair_req_i same IDLE cycle -> write to 0x4000 issued first, then fill read; ack delayed until WB accepted.
- mem_req_rdy_i low 4 cycles in FILL_REQ -> vld/addr stable all 4 cycles, single read issued.
- flush_i asserted during FILL_WAIT -> block still installed, repair_complete_o stays 0.
- No response for 1024 cycles -> timeout_err_o rises, stays high; async reset mid-FILL_WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/dcache_refill_controller_pkg.sv
// Shared definitions for the L1 data-cache refill path: default geometry,
// refill sequencer states and block alignment helper.
package dcache_refill_controller_pkg;

  localparam int DEF_BLOCK_BITS     = 128;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_ROB_ENTRIES    = 32;

  typedef logic [DEF_BLOCK_BITS-1:0] cache_data_block_t;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT,
    FILL_WRITE
  } refill_state_e;

  function automatic logic [31:0] block_align(input logic [31:0] addr, input int unsigned off_w);
    return addr & ~((32'd1 << off_w) - 32'd1);
  endfunction

endpackage

// File: rtl/dcache_refill_controller_wb_buffer.sv
// Single-entry victim writeback buffer; accepts a dirty block whenever empty
// and holds it until the sequencer has handed it to memory.
module dcache_refill_controller_wb_buffer #(
  parameter int BLOCK_BITS = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_vld_i,
  input  logic [31:0]           wb_addr_i,
  input  logic [BLOCK_BITS-1:0] wb_data_i,
  input  logic                  clr_i,
  output logic                  buf_vld_o,
  output logic [31:0]           buf_addr_o,
  output logic [BLOCK_BITS-1:0] buf_data_o,
  output logic                  wb_rdy_o
);

  logic                  vld_q, vld_d;
  logic [31:0]           addr_q, addr_d;
  logic [BLOCK_BITS-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (clr_i) vld_d = 1'b0;
    if (wb_vld_i && !vld_q) begin
      vld_d  = 1'b1;
      addr_d = wb_addr_i;
      data_d = wb_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign buf_vld_o  = vld_q;
  assign buf_addr_o = addr_q;
  assign buf_data_o = data_q;
  assign wb_rdy_o   = !vld_q;

endmodule

// File: rtl/dcache_refill_controller.sv
// Refill sequencer for the L1 data cache: drains victim writebacks, fetches
// missing blocks over the single memory port and installs them.
//
// state      | meaning
// IDLE       | waiting; pending writeback wins over a new repair
// WB_REQ     | block write of the victim buffer offered to memory
// FILL_REQ   | block read for the accepted miss offered to memory
// FILL_WAIT  | read accepted, waiting for data under the watchdog
// FILL_WRITE | one-cycle install into the cache, completion pulse
module dcache_refill_controller
  import dcache_refill_controller_pkg::*;
#(
  parameter int BLOCK_BITS     = DEF_BLOCK_BITS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int ROB_ENTRIES    = DEF_ROB_ENTRIES,
  localparam int RW            = $clog2(ROB_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  repair_req_i,
  input  logic [31:0]           repair_req_addr_i,
  input  logic [31:0]           repair_req_data_i,
  input  logic                  repair_is_store_i,
  input  logic [RW-1:0]         repair_req_rob_idx_i,
  output logic                  repair_ack_o,
  output logic                  repair_complete_o,
  output logic [RW-1:0]         repair_rob_idx_o,
  input  logic                  wb_vld_i,
  input  logic [31:0]           wb_addr_i,
  input  logic [BLOCK_BITS-1:0] wb_data_i,
  output logic                  wb_rdy_o,
  output logic                  mem_req_vld_o,
  output logic                  mem_req_we_o,
  output logic [31:0]           mem_req_addr_o,
  output logic [BLOCK_BITS-1:0] mem_req_data_o,
  input  logic                  mem_req_rdy_i,
  input  logic                  mem_resp_vld_i,
  input  logic [BLOCK_BITS-1:0] mem_resp_data_i,
  output logic                  cache_wr_en_o,
  output logic                  cache_is_repair_o,
  output logic                  cache_is_repair_dirty_o,
  output logic [31:0]           cache_wr_addr_o,
  output logic [BLOCK_BITS-1:0] cache_wr_data_o,
  output logic                  timeout_err_o
);

  localparam int OFF_W = $clog2(BLOCK_BITS/8);
  localparam int WI_W  = OFF_W - 2;
  localparam int WORDS = BLOCK_BITS/32;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

  refill_state_e         state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           sdata_q, sdata_d;
  logic                  store_q, store_d;
  logic [RW-1:0]         rob_q, rob_d;
  logic [BLOCK_BITS-1:0] fill_q, fill_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic                  err_q, err_d;
  logic                  flushed_q, flushed_d;

  logic                  wb_clr, wb_buf_vld;
  logic [31:0]           wb_buf_addr;
  logic [BLOCK_BITS-1:0] wb_buf_data;
  logic [BLOCK_BITS-1:0] merged;

  dcache_refill_controller_wb_buffer #(.BLOCK_BITS(BLOCK_BITS)) u_wb_buffer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wb_vld_i   (wb_vld_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .clr_i      (wb_clr),
    .buf_vld_o  (wb_buf_vld),
    .buf_addr_o (wb_buf_addr),
    .buf_data_o (wb_buf_data),
    .wb_rdy_o   (wb_rdy_o)
  );

  // Store misses overwrite their word of the fill so the line installs dirty and current.
  always_comb begin
    merged = fill_q;
    for (int i = 0; i < WORDS; i++) begin
      if (store_q && (addr_q[OFF_W-1:2] == WI_W'(i))) merged[32*i +: 32] = sdata_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    store_d   = store_q;
    rob_d     = rob_q;
    fill_d    = fill_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    flushed_d = flushed_q;
    wb_clr    = 1'b0;

    repair_ack_o            = 1'b0;
    repair_complete_o       = 1'b0;
    repair_rob_idx_o        = '0;
    mem_req_vld_o           = 1'b0;
    mem_req_we_o            = 1'b0;
    mem_req_addr_o          = '0;
    mem_req_data_o          = '0;
    cache_wr_en_o           = 1'b0;
    cache_is_repair_o       = 1'b0;
    cache_is_repair_dirty_o = 1'b0;
    cache_wr_addr_o         = '0;
    cache_wr_data_o         = '0;

    if (flush_i && state_q != IDLE) flushed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (wb_buf_vld) begin
          state_d = WB_REQ;
        end else if (repair_req_i && !flush_i) begin
          repair_ack_o = 1'b1;
          addr_d       = repair_req_addr_i;
          sdata_d      = repair_req_data_i;
          store_d      = repair_is_store_i;
          rob_d        = repair_req_rob_idx_i;
          flushed_d    = 1'b0;
          state_d      = FILL_REQ;
        end
      end
      WB_REQ: begin
        mem_req_vld_o  = 1'b1;
        mem_req_we_o   = 1'b1;
        mem_req_addr_o = wb_buf_addr;
        mem_req_data_o = wb_buf_data;
        if (mem_req_rdy_i) begin
          wb_clr  = 1'b1;
          state_d = IDLE;
        end
      end
      FILL_REQ: begin
        mem_req_vld_o  = 1'b1;
        mem_req_addr_o = block_align(addr_q, OFF_W);
        if (mem_req_rdy_i) begin
          wdog_d  = WD_W'(TIMEOUT_CYCLES - 1);
          state_d = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (mem_resp_vld_i) begin
          fill_d  = mem_resp_data_i;
          state_d = FILL_WRITE;
        end else if (wdog_q == '0) begin
          err_d = 1'b1;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
      end
      FILL_WRITE: begin
        cache_wr_en_o           = 1'b1;
        cache_is_repair_o       = 1'b1;
        cache_is_repair_dirty_o = store_q;
        cache_wr_addr_o         = block_align(addr_q, OFF_W);
        cache_wr_data_o         = merged;
        repair_complete_o       = !(flushed_q || flush_i);
        repair_rob_idx_o        = rob_q;
        state_d                 = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sdata_q   <= '0;
      store_q   <= 1'b0;
      rob_q     <= '0;
      fill_q    <= '0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      store_q   <= store_d;
      rob_q     <= rob_d;
      fill_q    <= fill_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
      flushed_q <= flushed_d;
    end
  end

  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_dcache_refill_controller.sv
// Directed bench for the refill controller: a transaction-level model predicts
// every memory request and cache install, one process checks them per cycle.
module tb_dcache_refill_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         flush_i;
  logic         repair_req_i;
  logic [31:0]  repair_req_addr_i;
  logic [31:0]  repair_req_data_i;
  logic         repair_is_store_i;
  logic [4:0]   repair_req_rob_idx_i;
  logic         repair_ack_o;
  logic         repair_complete_o;
  logic [4:0]   repair_rob_idx_o;
  logic         wb_vld_i;
  logic [31:0]  wb_addr_i;
  logic [127:0] wb_data_i;
  logic         wb_rdy_o;
  logic         mem_req_vld_o;
  logic         mem_req_we_o;
  logic [31:0]  mem_req_addr_o;
  logic [127:0] mem_req_data_o;
  logic         mem_req_rdy_i;
  logic         mem_resp_vld_i;
  logic [127:0] mem_resp_data_i;
  logic         cache_wr_en_o;
  logic         cache_is_repair_o;
  logic         cache_is_repair_dirty_o;
  logic [31:0]  cache_wr_addr_o;
  logic [127:0] cache_wr_data_o;
  logic         timeout_err_o;

  always #5 clk_i = ~clk_i;

  dcache_refill_controller dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .repair_req_i(repair_req_i), .repair_req_addr_i(repair_req_addr_i),
    .repair_req_data_i(repair_req_data_i), .repair_is_store_i(repair_is_store_i),
    .repair_req_rob_idx_i(repair_req_rob_idx_i), .repair_ack_o(repair_ack_o),
    .repair_complete_o(repair_complete_o), .repair_rob_idx_o(repair_rob_idx_o),
    .wb_vld_i(wb_vld_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_rdy_o(wb_rdy_o),
    .mem_req_vld_o(mem_req_vld_o), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_req_rdy_i(mem_req_rdy_i), .mem_resp_vld_i(mem_resp_vld_i),
    .mem_resp_data_i(mem_resp_data_i), .cache_wr_en_o(cache_wr_en_o),
    .cache_is_repair_o(cache_is_repair_o), .cache_is_repair_dirty_o(cache_is_repair_dirty_o),
    .cache_wr_addr_o(cache_wr_addr_o), .cache_wr_data_o(cache_wr_data_o),
    .timeout_err_o(timeout_err_o)
  );

  typedef struct {logic we; logic [31:0] addr; logic [127:0] data;} mem_t;
  typedef struct {logic [31:0] addr; logic [127:0] data; logic dirty; logic complete; logic [4:0] rob;} inst_t;

  mem_t  exp_mem[$];
  inst_t exp_inst[$];

  int tests = 0, fails = 0, cyc = 0;
  int stall_left = 0, resp_delay = 3, resp_cnt = 0;
  logic [127:0] resp_data = '0;
  int n_ack = 0, n_cmp = 0, n_stall = 0, n_reads = 0;
  int ack_cyc = 0, inst_cyc = 0, wb_cyc = 0;
  logic [127:0] last_data = '0;
  logic [31:0]  last_addr = '0, last_rd_addr = '0;
  logic         last_dirty = 1'b0;
  logic         prev_vld = 1'b0, prev_granted = 1'b0, prev_we = 1'b0;
  logic [31:0]  prev_addr = '0;
  logic [127:0] prev_data = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: block = four 32-bit words; a store replaces word (addr mod 16)/4.
  function automatic logic [127:0] model_fill(input logic [31:0] a, input bit st,
                                              input logic [31:0] sd, input logic [127:0] resp);
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = resp[32*i +: 32];
    if (st) w[(a % 16) / 4] = sd;
    return {w[3], w[2], w[1], w[0]};
  endfunction

  // Memory responder and per-cycle comparator.
  initial begin
    mem_t  m;
    inst_t e;
    mem_req_rdy_i = 1'b0; mem_resp_vld_i = 1'b0; mem_resp_data_i = '0;
    forever begin
      @(negedge clk_i); #2;
      cyc++;
      if (!rst_i) begin
        mem_req_rdy_i = 1'b0; mem_resp_vld_i = 1'b0; resp_cnt = 0; prev_vld = 1'b0;
        continue;
      end
      mem_resp_vld_i = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_vld_i  = 1'b1;
          mem_resp_data_i = resp_data;
        end
      end
      mem_req_rdy_i = 1'b0;
      if (mem_req_vld_o) begin
        if (prev_vld && !prev_granted) begin
          check("req_hold_addr", mem_req_addr_o, prev_addr);
          check("req_hold_we", mem_req_we_o, prev_we);
          check("req_hold_data", mem_req_data_o, prev_data);
        end
        if (stall_left > 0) begin
          stall_left--; n_stall++; prev_granted = 1'b0;
        end else begin
          mem_req_rdy_i = 1'b1; prev_granted = 1'b1;
          check("mem_req_expected", exp_mem.size() > 0, 1);
          if (exp_mem.size() > 0) begin
            m = exp_mem.pop_front();
            check("mem_req_we", mem_req_we_o, m.we);
            check("mem_req_addr", mem_req_addr_o, m.addr);
            check("mem_req_data", mem_req_data_o, m.data);
          end
          if (!mem_req_we_o) begin
            n_reads++; last_rd_addr = mem_req_addr_o;
            if (resp_delay > 0) resp_cnt = resp_delay;
          end else wb_cyc = cyc;
        end
      end
      prev_vld = mem_req_vld_o; prev_we = mem_req_we_o;
      prev_addr = mem_req_addr_o; prev_data = mem_req_data_o;
      if (repair_ack_o) begin n_ack++; ack_cyc = cyc; end
      if (repair_complete_o) n_cmp++;
      check("ack_complete_excl", repair_ack_o && repair_complete_o, 0);
      if (cache_wr_en_o) begin
        check("install_expected", exp_inst.size() > 0, 1);
        if (exp_inst.size() > 0) begin
          e = exp_inst.pop_front();
          check("inst_addr", cache_wr_addr_o, e.addr);
          check("inst_data", cache_wr_data_o, e.data);
          check("inst_dirty", cache_is_repair_dirty_o, e.dirty);
          check("inst_is_repair", cache_is_repair_o, 1);
          check("inst_complete", repair_complete_o, e.complete);
          if (e.complete) check("inst_rob", repair_rob_idx_o, e.rob);
        end
        last_data = cache_wr_data_o; last_addr = cache_wr_addr_o;
        last_dirty = cache_is_repair_dirty_o; inst_cyc = cyc;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input bit st, input logic [31:0] sd,
                       input logic [4:0] rob, input logic [127:0] resp, input bit cmp);
    mem_t  m;
    inst_t e;
    bit    got = 0;
    m.we = 1'b0; m.addr = a - (a % 16); m.data = '0;
    exp_mem.push_back(m);
    if (resp_delay > 0) begin
      e.addr = a - (a % 16); e.data = model_fill(a, st, sd, resp);
      e.dirty = st; e.complete = cmp; e.rob = rob;
      exp_inst.push_back(e);
    end
    resp_data = resp;
    repair_req_addr_i = a; repair_req_data_i = sd;
    repair_is_store_i = st; repair_req_rob_idx_i = rob;
    repair_req_i = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      #3;
      if (repair_ack_o) got = 1;
      @(negedge clk_i);
    end
    repair_req_i = 1'b0;
    check("ack_seen", got, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_mem.size() != 0 || exp_inst.size() != 0) && n < 200) begin
      @(negedge clk_i); n++;
    end
    check("drain", exp_mem.size() + exp_inst.size(), 0);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    mem_t w;
    int   reads0;
    rst_i = 1'b0; flush_i = 1'b0; repair_req_i = 1'b0;
    repair_req_addr_i = '0; repair_req_data_i = '0; repair_is_store_i = 1'b0;
    repair_req_rob_idx_i = '0; wb_vld_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_mem_vld", mem_req_vld_o, 0);
    check("rst_wr_en", cache_wr_en_o, 0);
    check("rst_ack", repair_ack_o, 0);
    check("rst_complete", repair_complete_o, 0);
    check("rst_timeout", timeout_err_o, 0);
    check("rst_wb_rdy", wb_rdy_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Load miss, immediate rdy, response 3 cycles after handshake
    issue(32'h0000_1234, 0, 32'h0, 5'd5, 128'h11112222_33334444_55556666_77778888, 1);
    drain();
    check("t1_rd_addr", last_rd_addr, 32'h0000_1230);
    check("t1_inst_addr", last_addr, 32'h0000_1230);
    check("t1_inst_data", last_data, 128'h11112222_33334444_55556666_77778888);
    check("t1_dirty", last_dirty, 0);
    check("t1_latency", inst_cyc - ack_cyc, 5);
    check("t1_complete_cnt", n_cmp, 1);

    // Store miss merges word 2
    issue(32'h0000_1238, 1, 32'hDEAD_BEEF, 5'd7, 128'h0, 1);
    drain();
    check("t2_data", last_data, 128'h00000000_DEADBEEF_00000000_00000000);
    check("t2_dirty", last_dirty, 1);

    // Writeback pending together with repair: write goes first, ack after
    wb_vld_i = 1'b1; wb_addr_i = 32'h0000_4000; wb_data_i = {4{32'hA5A5_5A5A}};
    w.we = 1'b1; w.addr = 32'h0000_4000; w.data = {4{32'hA5A5_5A5A}};
    exp_mem.push_back(w);
    @(negedge clk_i);
    wb_vld_i = 1'b0;
    #1 check("t3_wb_rdy_low", wb_rdy_o, 0);
    issue(32'h0000_2004, 0, 32'h0, 5'd3, 128'hCAFE0000_CAFE0001_CAFE0002_CAFE0003, 1);
    drain();
    check("t3_ack_after_wb", ack_cyc > wb_cyc, 1);
    check("t3_wb_rdy_back", wb_rdy_o, 1);

    // Memory stalls the fill read for 4 cycles
    n_stall = 0; reads0 = n_reads; stall_left = 4;
    issue(32'h0000_8010, 0, 32'h0, 5'd9, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 1);
    drain();
    check("t4_stall_cycles", n_stall, 4);
    check("t4_single_read", n_reads - reads0, 1);

    // Flush in IDLE blocks acceptance; flush in FILL_WAIT suppresses completion
    flush_i = 1'b1; repair_req_i = 1'b1; repair_req_addr_i = 32'h0000_300C;
    #3 check("t5_flush_blocks_ack", repair_ack_o, 0);
    @(negedge clk_i);
    flush_i = 1'b0; resp_delay = 6;
    issue(32'h0000_300C, 1, 32'h1357_9BDF, 5'd11, 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000, 0);
    repeat (2) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    drain();
    check("t5_data", last_data, 128'h13579BDF_00000000_FFFFFFFF_00000000);
    check("t5_complete_cnt", n_cmp, 4);

    // No response: watchdog fires after 1024 waiting cycles, then async reset
    resp_delay = -1;
    issue(32'h0000_5000, 0, 32'h0, 5'd1, 128'h0, 0);
    repeat (1015) @(negedge clk_i);
    check("t6_no_early_timeout", timeout_err_o, 0);
    repeat (20) @(negedge clk_i);
    check("t6_timeout", timeout_err_o, 1);
    repeat (5) @(negedge clk_i);
    check("t6_timeout_sticky", timeout_err_o, 1);
    check("t6_read_issued", exp_mem.size(), 0);
    #3 rst_i = 1'b0;
    #1;
    check("t6_rst_timeout", timeout_err_o, 0);
    check("t6_rst_mem_vld", mem_req_vld_o, 0);
    check("t6_rst_wr_en", cache_wr_en_o, 0);
    check("t6_rst_complete", repair_complete_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1; resp_delay = 3;
    repeat (2) @(negedge clk_i);

    check("total_acks", n_ack, 6);
    check("total_completes", n_cmp, 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
